tff_bank: RTL

Multi-channel, clocked successor to the single asynchronous temporal flip-flop cell. Holds CHANNELS independent ring-phase accumulators. Each accumulator advances one phase per clock while its write enable is held. A shared read port uses a request/valid handshake to run a selected ring back to phase 0, measuring the stored value by counting the cycles this takes. It sits between the pulse-accumulating front end and the readout/serialiser logic, and adds overflow policy selection, sticky carry, and arbitration between writes and reads.

---
 rtl/tff_pkg.sv | 24 ++
 rtl/tff_phase_cell.sv | 61 ++++++
 rtl/tff_bank.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/tff_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tff_pkg : read-FSM encoding and sizing helpers for tff_bank           |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package tff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } rd_state_t;

    // Phases per ring: two ring traversals (2 * 2**bits).
    function automatic int phases_of(input int bits);
        return 2 * (1 << bits);
    endfunction

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tff_phase_cell.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tff_phase_cell : one ring-phase accumulator with sticky carry         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tff_phase_cell
    import tff_pkg::*;
#(
    parameter  int BITS      = 2,
    parameter  int SAT_MODE  = 0,
    localparam int RING_SEGS = 1 << BITS,
    localparam int PHASES    = phases_of(BITS),
    localparam int PW        = $clog2(PHASES)
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          adv,
    input  logic          lock_adv,
    input  logic          clr_carry,
    output logic [PW-1:0] phase,
    output logic          out,
    output logic          carry
);

    localparam logic [PW-1:0] c_max  = PW'(PHASES - 1);
    localparam logic [PW-1:0] c_half = PW'(RING_SEGS);

    logic [PW-1:0] r_phase;
    logic          r_carry;

    // Read-driven advance wraps freely and never touches carry; the top
    // guarantees adv and lock_adv are never both set for one channel.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_phase <= '0;
            r_carry <= 1'b0;
        end else begin
            if (lock_adv) begin
                r_phase <= r_phase + PW'(1);
            end else if (adv) begin
                if (r_phase == c_max) begin
                    r_carry <= 1'b1;
                    if (SAT_MODE == 0) begin
                        r_phase <= '0;
                    end
                end else begin
                    r_phase <= r_phase + PW'(1);
                end
            end
            if (clr_carry) begin
                r_carry <= 1'b0;
            end
        end
    end

    assign phase = r_phase;
    assign out   = (r_phase >= c_half);
    assign carry = r_carry;

endmodule
`default_nettype wire

// File: rtl/tff_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tff_bank : multi-channel ring-phase accumulators with counted readout |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tff_bank
    import tff_pkg::*;
#(
    parameter  int CHANNELS = 4,
    parameter  int BITS     = 2,
    parameter  int SAT_MODE = 0,
    localparam int PHASES   = phases_of(BITS),
    localparam int PW       = $clog2(PHASES),
    localparam int CHW      = clog2_min1(CHANNELS)
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic [CHANNELS-1:0] we,
    input  logic                rd_req,
    input  logic [CHW-1:0]      rd_ch,
    output logic                rd_busy,
    output logic                rd_valid,
    output logic [PW-1:0]       rd_data,
    output logic                rd_carry,
    output logic                rd_err,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] carry
);

    localparam logic [PW-1:0] c_max    = PW'(PHASES - 1);
    localparam logic [CHW:0]  c_ch_lim = (CHW + 1)'(CHANNELS);

    rd_state_t      r_state;
    logic [CHW-1:0] r_ch;
    logic [PW-1:0]  r_count;
    logic           r_busy;
    logic           r_valid;
    logic           r_err;
    logic [PW-1:0]  r_data;
    logic           r_rcarry;

    logic [PW-1:0]       w_phase [CHANNELS];
    logic [CHANNELS-1:0] w_lock;
    logic [CHANNELS-1:0] w_adv;
    logic [CHANNELS-1:0] w_lock_adv;
    logic [CHANNELS-1:0] w_clr;
    logic [PW-1:0]       w_req_phase;
    logic                w_req_carry;
    logic [PW-1:0]       w_run_phase;
    logic                w_run_carry;
    logic [PW-1:0]       w_count_nxt;
    logic                w_ch_ok;
    logic                w_accept;

    assign w_ch_ok     = ({1'b0, rd_ch} < c_ch_lim);
    assign w_accept    = (r_state == ST_IDLE) && rd_req && w_ch_ok;
    assign w_count_nxt = r_count + PW'(1);

    // Explicit compare-mux so an out-of-range rd_ch never indexes past the array.
    always_comb begin
        w_req_phase = '0;
        w_req_carry = 1'b0;
        w_run_phase = '0;
        w_run_carry = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (rd_ch == CHW'(i)) begin
                w_req_phase = w_phase[i];
                w_req_carry = carry[i];
            end
            if (r_ch == CHW'(i)) begin
                w_run_phase = w_phase[i];
                w_run_carry = carry[i];
            end
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        // Locked from the accepting cycle through DONE; dropped writes are lost.
        assign w_lock[gi]     = (w_accept && (rd_ch == CHW'(gi))) ||
                                ((r_state != ST_IDLE) && (r_ch == CHW'(gi)));
        assign w_adv[gi]      = we[gi] && !w_lock[gi];
        assign w_lock_adv[gi] = (r_state == ST_RUN) && (r_ch == CHW'(gi));
        assign w_clr[gi]      = (r_state == ST_DONE) && (r_ch == CHW'(gi));

        tff_phase_cell #(
            .BITS     (BITS),
            .SAT_MODE (SAT_MODE)
        ) u_cell (
            .clk       (clk),
            .rstb      (rstb),
            .adv       (w_adv[gi]),
            .lock_adv  (w_lock_adv[gi]),
            .clr_carry (w_clr[gi]),
            .phase     (w_phase[gi]),
            .out       (out[gi]),
            .carry     (carry[gi])
        );
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state  <= ST_IDLE;
            r_ch     <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_data   <= '0;
            r_rcarry <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (rd_req) begin
                        if (!w_ch_ok) begin
                            r_err <= 1'b1;
                        end else begin
                            r_ch    <= rd_ch;
                            r_count <= '0;
                            r_busy  <= 1'b1;
                            if (w_req_phase == '0) begin
                                r_state  <= ST_DONE;
                                r_valid  <= 1'b1;
                                r_data   <= '0;
                                r_rcarry <= w_req_carry;
                            end else begin
                                r_state <= ST_RUN;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    r_count <= w_count_nxt;
                    // Stored phase is (PHASES - cycles to wrap) mod PHASES.
                    if (w_run_phase == c_max) begin
                        r_state  <= ST_DONE;
                        r_valid  <= 1'b1;
                        r_data   <= PW'(0) - w_count_nxt;
                        r_rcarry <= w_run_carry;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_busy  = r_busy;
    assign rd_valid = r_valid;
    assign rd_data  = r_data;
    assign rd_carry = r_rcarry;
    assign rd_err   = r_err;

endmodule
`default_nettype wire
